gray_sequence_decoder: RTL and testbench
========================================

# gray_sequence_decoder

Registered Gray-to-binary decoder with sequence checking. It sits directly downstream of the binary-to-Gray converter, or any Gray-coded source such as an encoder or position counter. Each valid Gray sample is converted back to binary and compared with the previous sample, which gives a step direction. Illegal multi-bit transitions are flagged and counted, and the decoder only reports lock after a run of legal steps.

## Interface
- WIDTH, 4, Gray/binary word width (≥2)
- RELOCK_COUNT, 2, consecutive legal single-bit steps required to reach LOCKED (≥1)
- ERR_CNT_WIDTH, 8, width of saturating error counter
- Clock_In  input  1  single clock; all logic on rising edge
- Reset_n_In  input  1  synchronous, active-low reset
- Enable_In  input  1  block enable; when low, inputs ignored and all state held
- Clear_Errors_In  input  1  synchronous clear of Error_Count_Out
- Gray_Valid_In  input  1  Gray_Data_In qualifier
- Gray_Data_In  input  WIDTH  Gray-coded sample
- Binary_Data_Out  output  WIDTH  decoded binary of last accepted sample
- Binary_Valid_Out  output  1  one-cycle pulse per accepted sample
- Direction_Out  output  2  00 hold/first, 01 up, 10 down, 11 illegal step
- Step_Error_Out  output  1  one-cycle pulse on illegal step
- Error_Count_Out  output  ERR_CNT_WIDTH  saturating illegal-step count
- Locked_Out  output  1  high only in LOCKED state

## Operation
- A sample is accepted when Reset_n_In=1, Enable_In=1 and Gray_Valid_In=1.
- Decode: B[W-1]=G[W-1]; B[i]=B[i+1]^G[i], evaluated combinationally from Gray_Data_In and registered on acceptance.
- Reference register holds the previous accepted Gray word. It is updated on every accepted sample, including illegal ones.
- Step classification against the reference:
  - Hamming distance 0: hold, Direction 00.
  - Distance 1: legal. Up (01) if B_new = B_prev+1 mod 2^WIDTH, otherwise down (10). Wrap-around from 2^WIDTH−1 to 0 is up; 0 to 2^WIDTH−1 is down.
  - Distance ≥2: illegal. Direction 11, Step_Error_Out pulses, Error_Count_Out increments.
- Error_Count_Out saturates at all-ones.
- Clear_Errors_In zeroes the count. If it coincides with an illegal step, the count becomes 1.
- State machine:
  - IDLE: no reference held. The first accepted sample loads the reference, outputs Direction 00, sets the relock counter to 0, and moves to RESYNC. No error check is made.
  - RESYNC: a legal step increments the relock counter; reaching RELOCK_COUNT moves to LOCKED. A hold sample leaves the counter unchanged. An illegal step zeroes the counter and stays in RESYNC.
  - LOCKED: legal and hold samples stay in LOCKED. An illegal step moves to RESYNC with the counter at 0.
- Enable_In=0: no acceptance, state, reference, counters and data outputs frozen. Pulse outputs are 0.

## Timing
- All outputs are registered. An accepted sample at edge N is reflected at edge N+1.
- Latency is 1 cycle. Throughput is one sample per cycle, back-to-back.
- Binary_Valid_Out and Step_Error_Out are high for exactly one cycle per accepted sample or illegal step.
- Binary_Data_Out and Direction_Out hold their value between accepted samples.
- Locked_Out changes on the same edge as the sample that causes the transition.
- Reset (Reset_n_In=0 at an edge) returns to IDLE, including mid-operation, and overrides Enable_In and Clear_Errors_In. All outputs go to 0: Binary_Data_Out=0, Binary_Valid_Out=0, Direction_Out=00, Step_Error_Out=0, Error_Count_Out=0, Locked_Out=0. Reference and relock counter are cleared.
- There is no backpressure; the source may present a sample every cycle.

## Test plan
- Reset, then WIDTH=4 Gray sequence 0000,0001,0011,0010 on consecutive cycles: Binary_Data_Out 0,1,2,3 one cycle later, Direction 00,01,01,01, Locked_Out rises with the third sample's output (RELOCK_COUNT=2), Error_Count_Out=0.
- Wrap-around from lock at binary 15 (Gray 1000): apply 0000 → Binary 0, Direction 01. Then apply 1000 → Binary 15, Direction 10. Locked_Out stays 1.
- Illegal step while LOCKED at Gray 0010: apply 0101 → Direction 11, Step_Error_Out pulse, Error_Count_Out=1, Locked_Out=0. Then 0111,0110 → relock on the second step. A hold sample (repeat 0111) in between does not advance relock.
- Saturation and clear with ERR_CNT_WIDTH=2: four illegal steps → count 3, held at 3. Clear_Errors_In together with a fifth illegal step → count 1.
- Enable_In=0 for 3 cycles with Gray_Valid_In=1 and changing data: no valid pulses, outputs frozen. Re-enable and the next sample is compared against the pre-disable reference.
- Reset_n_In low for one cycle while LOCKED: all outputs 0, IDLE. The next sample gives Direction 00 with no error.

Source files
------------

// File: rtl/gray_sequence_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : gray_sequence_decoder
//  Purpose  : Registered Gray-to-binary decoder with step-sequence checking.
//             Each accepted Gray sample is decoded to binary. It is then
//             classified against the previously accepted sample as a hold,
//             an up step, a down step or an illegal multi-bit jump. Illegal
//             jumps are counted in a saturating counter. Lock is reported
//             only after RELOCK_COUNT consecutive legal steps.
//  Ports    : Clock_In         - rising-edge clock
//             Reset_n_In       - synchronous active-low reset
//             Enable_In        - block enable; when low all state is held
//             Clear_Errors_In  - synchronous clear of the error counter
//             Gray_Valid_In    - qualifier for Gray_Data_In
//             Gray_Data_In     - Gray-coded sample
//             Binary_Data_Out  - decoded binary of the last accepted sample
//             Binary_Valid_Out - one-cycle pulse per accepted sample
//             Direction_Out    - 00 hold/first, 01 up, 10 down, 11 illegal
//             Step_Error_Out   - one-cycle pulse on an illegal step
//             Error_Count_Out  - saturating illegal-step count
//             Locked_Out       - high while in the LOCKED state
//  Revision : 1.0 - initial release
// ============================================================================
module gray_sequence_decoder #(
    parameter int WIDTH         = 4,
    parameter int RELOCK_COUNT  = 2,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     Clock_In,
    input  logic                     Reset_n_In,
    input  logic                     Enable_In,
    input  logic                     Clear_Errors_In,
    input  logic                     Gray_Valid_In,
    input  logic [WIDTH-1:0]         Gray_Data_In,
    output logic [WIDTH-1:0]         Binary_Data_Out,
    output logic                     Binary_Valid_Out,
    output logic [1:0]               Direction_Out,
    output logic                     Step_Error_Out,
    output logic [ERR_CNT_WIDTH-1:0] Error_Count_Out,
    output logic                     Locked_Out
);

    localparam int                      c_RELOCK_W      = $clog2(RELOCK_COUNT + 1);
    localparam logic [c_RELOCK_W-1:0]   c_RELOCK_TARGET = c_RELOCK_W'(RELOCK_COUNT);
    localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_MAX      = '1;

    localparam logic [1:0] c_DIR_HOLD    = 2'b00;
    localparam logic [1:0] c_DIR_UP      = 2'b01;
    localparam logic [1:0] c_DIR_DOWN    = 2'b10;
    localparam logic [1:0] c_DIR_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESYNC = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                   r_state, w_state_next;
    logic [WIDTH-1:0]         r_ref, w_ref_next;
    logic [c_RELOCK_W-1:0]    r_relock_cnt, w_relock_cnt_next;
    logic [WIDTH-1:0]         r_binary, w_binary_next;
    logic                     r_valid, w_valid_next;
    logic [1:0]               r_direction, w_direction_next;
    logic                     r_step_error, w_step_error_next;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt, w_err_cnt_next;

    logic                     w_accept;
    logic [WIDTH-1:0]         w_bin;
    logic [WIDTH-1:0]         w_bin_inc;
    logic [WIDTH-1:0]         w_diff;
    logic                     w_is_hold;
    logic                     w_is_single;

    assign w_accept = Enable_In && Gray_Valid_In;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_bin            = '0;
        w_bin[WIDTH-1]   = Gray_Data_In[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            w_bin[i] = w_bin[i+1] ^ Gray_Data_In[i];
        end
    end

    // The registered binary output always equals the decoded reference once
    // a sample has been accepted, so it doubles as the previous binary value.
    assign w_bin_inc   = r_binary + WIDTH'(1);
    assign w_diff      = Gray_Data_In ^ r_ref;
    assign w_is_hold   = (w_diff == '0);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
    assign w_is_single = !w_is_hold && ((w_diff & (w_diff - WIDTH'(1))) == '0);

    always_ff @(posedge Clock_In) begin
        if (!Reset_n_In) begin
            r_state      <= ST_IDLE;
            r_ref        <= '0;
            r_relock_cnt <= '0;
            r_binary     <= '0;
            r_valid      <= 1'b0;
            r_direction  <= c_DIR_HOLD;
            r_step_error <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_state      <= w_state_next;
            r_ref        <= w_ref_next;
            r_relock_cnt <= w_relock_cnt_next;
            r_binary     <= w_binary_next;
            r_valid      <= w_valid_next;
            r_direction  <= w_direction_next;
            r_step_error <= w_step_error_next;
            r_err_cnt    <= w_err_cnt_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_ref_next        = r_ref;
        w_relock_cnt_next = r_relock_cnt;
        w_binary_next     = r_binary;
        w_valid_next      = 1'b0;
        w_direction_next  = r_direction;
        w_step_error_next = 1'b0;
        w_err_cnt_next    = r_err_cnt;

        // A clear without a coinciding illegal step simply zeroes the count.
        if (Enable_In && Clear_Errors_In) begin
            w_err_cnt_next = '0;
        end

        if (w_accept) begin
            w_ref_next    = Gray_Data_In;
            w_binary_next = w_bin;
            w_valid_next  = 1'b1;

            case (r_state)
                ST_IDLE: begin
                    w_direction_next  = c_DIR_HOLD;
                    w_relock_cnt_next = '0;
                    w_state_next      = ST_RESYNC;
                end
                ST_RESYNC, ST_LOCKED: begin
                    if (w_is_hold) begin
                        w_direction_next = c_DIR_HOLD;
                    end else if (w_is_single) begin
                        w_direction_next = (w_bin == w_bin_inc) ? c_DIR_UP : c_DIR_DOWN;
                        if (r_state == ST_RESYNC) begin
                            w_relock_cnt_next = r_relock_cnt + c_RELOCK_W'(1);
                            if (w_relock_cnt_next == c_RELOCK_TARGET) begin
                                w_state_next = ST_LOCKED;
                            end
                        end
                    end else begin
                        w_direction_next  = c_DIR_ILLEGAL;
                        w_step_error_next = 1'b1;
                        w_relock_cnt_next = '0;
                        w_state_next      = ST_RESYNC;
                        if (Clear_Errors_In) begin
                            w_err_cnt_next = ERR_CNT_WIDTH'(1);
                        end else if (r_err_cnt != c_ERR_MAX) begin
                            w_err_cnt_next = r_err_cnt + ERR_CNT_WIDTH'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign Binary_Data_Out  = r_binary;
    assign Binary_Valid_Out = r_valid;
    assign Direction_Out    = r_direction;
    assign Step_Error_Out   = r_step_error;
    assign Error_Count_Out  = r_err_cnt;
    assign Locked_Out       = (r_state == ST_LOCKED);

endmodule
`default_nettype wire

// File: tb/tb_gray_sequence_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_sequence_decoder
//  Purpose  : Directed self-checking bench for gray_sequence_decoder with
//             WIDTH=4, RELOCK_COUNT=2 and a 2-bit error counter so that
//             saturation can be reached quickly.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_sequence_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       clear_errors;
    logic       gray_valid;
    logic [3:0] gray_data;
    logic [3:0] binary_data;
    logic       binary_valid;
    logic [1:0] direction;
    logic       step_error;
    logic [1:0] error_count;
    logic       locked;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gray_sequence_decoder #(
        .WIDTH         (4),
        .RELOCK_COUNT  (2),
        .ERR_CNT_WIDTH (2)
    ) dut (
        .Clock_In         (clk),
        .Reset_n_In       (rst_n),
        .Enable_In        (enable),
        .Clear_Errors_In  (clear_errors),
        .Gray_Valid_In    (gray_valid),
        .Gray_Data_In     (gray_data),
        .Binary_Data_Out  (binary_data),
        .Binary_Valid_Out (binary_valid),
        .Direction_Out    (direction),
        .Step_Error_Out   (step_error),
        .Error_Count_Out  (error_count),
        .Locked_Out       (locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Applies one accepted sample and lands 1 time unit after the capturing edge.
    task automatic send(input logic [3:0] g);
        gray_data  = g;
        gray_valid = 1'b1;
        tick();
        gray_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear_errors = 1'b0;
        gray_valid = 1'b0; gray_data = 4'h0;
        tick(); tick();
        n_checks++; if (binary_data !== 4'd0) begin n_fail++; $display("FAIL reset_bin: got %0d want 0", binary_data); end
        n_checks++; if (binary_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", binary_valid); end
        n_checks++; if (direction !== 2'b00) begin n_fail++; $display("FAIL reset_dir: got %b want 00", direction); end
        n_checks++; if (step_error !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", step_error); end
        n_checks++; if (error_count !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", error_count); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_lock: got %b want 0", locked); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_sequence();
        logic [3:0] g   [4] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        logic [3:0] b   [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
        logic [1:0] d   [4] = '{2'b00, 2'b01, 2'b01, 2'b01};
        logic       lk  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            send(g[i]);
            n_checks++; if (binary_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, binary_valid); end
            n_checks++; if (binary_data !== b[i]) begin n_fail++; $display("FAIL seq_bin[%0d]: got %0d want %0d", i, binary_data, b[i]); end
            n_checks++; if (direction !== d[i]) begin n_fail++; $display("FAIL seq_dir[%0d]: got %b want %b", i, direction, d[i]); end
            n_checks++; if (locked !== lk[i]) begin n_fail++; $display("FAIL seq_lock[%0d]: got %b want %b", i, locked, lk[i]); end
            n_checks++; if (step_error !== 1'b0) begin n_fail++; $display("FAIL seq_err[%0d]: got %b want 0", i, step_error); end
            n_checks++; if (error_count !== 2'd0) begin n_fail++; $display("FAIL seq_cnt[%0d]: got %0d want 0", i, error_count); end
        end
        // Idle cycle: valid drops after one cycle, data and direction hold.
        tick();
        n_checks++; if (binary_valid !== 1'b0) begin n_fail++; $display("FAIL seq_idle_valid: got %b want 0", binary_valid); end
        n_checks++; if (binary_data !== 4'd3) begin n_fail++; $display("FAIL seq_idle_bin: got %0d want 3", binary_data); end
        n_checks++; if (direction !== 2'b01) begin n_fail++; $display("FAIL seq_idle_dir: got %b want 01", direction); end
    endtask

    task automatic test_wrap();
        // Walk down from binary 3 to binary 15 via wrap-around.
        logic [3:0] g [4] = '{4'b0011, 4'b0001, 4'b0000, 4'b1000};
        logic [3:0] b [4] = '{4'd2, 4'd1, 4'd0, 4'd15};
        for (int i = 0; i < 4; i++) begin
            send(g[i]);
            n_checks++; if (binary_data !== b[i]) begin n_fail++; $display("FAIL down_bin[%0d]: got %0d want %0d", i, binary_data, b[i]); end
            n_checks++; if (direction !== 2'b10) begin n_fail++; $display("FAIL down_dir[%0d]: got %b want 10", i, direction); end
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL down_lock[%0d]: got %b want 1", i, locked); end
        end
        send(4'b0000);
        n_checks++; if (binary_data !== 4'd0) begin n_fail++; $display("FAIL wrap_up_bin: got %0d want 0", binary_data); end
        n_checks++; if (direction !== 2'b01) begin n_fail++; $display("FAIL wrap_up_dir: got %b want 01", direction); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL wrap_up_lock: got %b want 1", locked); end
        send(4'b1000);
        n_checks++; if (binary_data !== 4'd15) begin n_fail++; $display("FAIL wrap_dn_bin: got %0d want 15", binary_data); end
        n_checks++; if (direction !== 2'b10) begin n_fail++; $display("FAIL wrap_dn_dir: got %b want 10", direction); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL wrap_dn_lock: got %b want 1", locked); end
    endtask

    task automatic test_illegal();
        // Climb back to Gray 0010 (binary 3).
        send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010);
        n_checks++; if (binary_data !== 4'd3) begin n_fail++; $display("FAIL ill_pre_bin: got %0d want 3", binary_data); end
        send(4'b0101);
        n_checks++; if (binary_data !== 4'd6) begin n_fail++; $display("FAIL ill_bin: got %0d want 6", binary_data); end
        n_checks++; if (direction !== 2'b11) begin n_fail++; $display("FAIL ill_dir: got %b want 11", direction); end
        n_checks++; if (step_error !== 1'b1) begin n_fail++; $display("FAIL ill_err: got %b want 1", step_error); end
        n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL ill_cnt: got %0d want 1", error_count); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL ill_lock: got %b want 0", locked); end
        send(4'b0111);
        n_checks++; if (binary_data !== 4'd5) begin n_fail++; $display("FAIL rl1_bin: got %0d want 5", binary_data); end
        n_checks++; if (direction !== 2'b10) begin n_fail++; $display("FAIL rl1_dir: got %b want 10", direction); end
        n_checks++; if (step_error !== 1'b0) begin n_fail++; $display("FAIL rl1_err: got %b want 0", step_error); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL rl1_lock: got %b want 0", locked); end
        send(4'b0111);
        n_checks++; if (direction !== 2'b00) begin n_fail++; $display("FAIL hold_dir: got %b want 00", direction); end
        n_checks++; if (binary_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b want 1", binary_valid); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL hold_lock: got %b want 0", locked); end
        send(4'b0110);
        n_checks++; if (binary_data !== 4'd4) begin n_fail++; $display("FAIL rl2_bin: got %0d want 4", binary_data); end
        n_checks++; if (direction !== 2'b10) begin n_fail++; $display("FAIL rl2_dir: got %b want 10", direction); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL rl2_lock: got %b want 1", locked); end
        n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL rl2_cnt: got %0d want 1", error_count); end
    endtask

    task automatic test_saturation();
        // Illegal steps from reference 0110, each a 2-bit change.
        logic [3:0] g [4] = '{4'b0000, 4'b0011, 4'b0000, 4'b0011};
        logic [1:0] c [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        clear_errors = 1'b1;
        tick();
        clear_errors = 1'b0;
        n_checks++; if (error_count !== 2'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", error_count); end
        n_checks++; if (binary_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b want 0", binary_valid); end
        for (int i = 0; i < 4; i++) begin
            send(g[i]);
            n_checks++; if (error_count !== c[i]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, error_count, c[i]); end
            n_checks++; if (step_error !== 1'b1) begin n_fail++; $display("FAIL sat_err[%0d]: got %b want 1", i, step_error); end
            n_checks++; if (direction !== 2'b11) begin n_fail++; $display("FAIL sat_dir[%0d]: got %b want 11", i, direction); end
        end
        tick();
        n_checks++; if (error_count !== 2'd3) begin n_fail++; $display("FAIL sat_hold_cnt: got %0d want 3", error_count); end
        n_checks++; if (step_error !== 1'b0) begin n_fail++; $display("FAIL sat_hold_err: got %b want 0", step_error); end
        clear_errors = 1'b1;
        send(4'b0000);
        clear_errors = 1'b0;
        n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL clr_ill_cnt: got %0d want 1", error_count); end
        n_checks++; if (step_error !== 1'b1) begin n_fail++; $display("FAIL clr_ill_err: got %b want 1", step_error); end
        // A clear while disabled must not touch the frozen count.
        enable = 1'b0; clear_errors = 1'b1;
        tick();
        enable = 1'b1; clear_errors = 1'b0;
        n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL dis_clr_cnt: got %0d want 1", error_count); end
    endtask

    task automatic test_enable();
        logic [3:0] g [3] = '{4'b1111, 4'b1010, 4'b0101};
        send(4'b0001); send(4'b0011);
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL en_pre_lock: got %b want 1", locked); end
        n_checks++; if (binary_data !== 4'd2) begin n_fail++; $display("FAIL en_pre_bin: got %0d want 2", binary_data); end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(g[i]);
            n_checks++; if (binary_valid !== 1'b0) begin n_fail++; $display("FAIL dis_valid[%0d]: got %b want 0", i, binary_valid); end
            n_checks++; if (binary_data !== 4'd2) begin n_fail++; $display("FAIL dis_bin[%0d]: got %0d want 2", i, binary_data); end
            n_checks++; if (direction !== 2'b01) begin n_fail++; $display("FAIL dis_dir[%0d]: got %b want 01", i, direction); end
            n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL dis_lock[%0d]: got %b want 1", i, locked); end
            n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL dis_cnt[%0d]: got %0d want 1", i, error_count); end
        end
        enable = 1'b1;
        // Legal against the pre-disable reference 0011, illegal against 0101.
        send(4'b0010);
        n_checks++; if (binary_data !== 4'd3) begin n_fail++; $display("FAIL reen_bin: got %0d want 3", binary_data); end
        n_checks++; if (direction !== 2'b01) begin n_fail++; $display("FAIL reen_dir: got %b want 01", direction); end
        n_checks++; if (step_error !== 1'b0) begin n_fail++; $display("FAIL reen_err: got %b want 0", step_error); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL reen_lock: got %b want 1", locked); end
    endtask

    task automatic test_reset_midop();
        rst_n = 1'b0; clear_errors = 1'b1;
        send(4'b1000);
        rst_n = 1'b1; clear_errors = 1'b0;
        n_checks++; if (binary_data !== 4'd0) begin n_fail++; $display("FAIL mrst_bin: got %0d want 0", binary_data); end
        n_checks++; if (binary_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %b want 0", binary_valid); end
        n_checks++; if (direction !== 2'b00) begin n_fail++; $display("FAIL mrst_dir: got %b want 00", direction); end
        n_checks++; if (error_count !== 2'd0) begin n_fail++; $display("FAIL mrst_cnt: got %0d want 0", error_count); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mrst_lock: got %b want 0", locked); end
        send(4'b0110);
        n_checks++; if (binary_data !== 4'd4) begin n_fail++; $display("FAIL first_bin: got %0d want 4", binary_data); end
        n_checks++; if (direction !== 2'b00) begin n_fail++; $display("FAIL first_dir: got %b want 00", direction); end
        n_checks++; if (step_error !== 1'b0) begin n_fail++; $display("FAIL first_err: got %b want 0", step_error); end
        n_checks++; if (binary_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", binary_valid); end
        send(4'b1111);
        n_checks++; if (binary_data !== 4'd10) begin n_fail++; $display("FAIL post_ill_bin: got %0d want 10", binary_data); end
        n_checks++; if (direction !== 2'b11) begin n_fail++; $display("FAIL post_ill_dir: got %b want 11", direction); end
        n_checks++; if (error_count !== 2'd1) begin n_fail++; $display("FAIL post_ill_cnt: got %0d want 1", error_count); end
        send(4'b1110);
        n_checks++; if (binary_data !== 4'd11) begin n_fail++; $display("FAIL post_up1_bin: got %0d want 11", binary_data); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL post_up1_lock: got %b want 0", locked); end
        send(4'b1010);
        n_checks++; if (binary_data !== 4'd12) begin n_fail++; $display("FAIL post_up2_bin: got %0d want 12", binary_data); end
        n_checks++; if (direction !== 2'b01) begin n_fail++; $display("FAIL post_up2_dir: got %b want 01", direction); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL post_up2_lock: got %b want 1", locked); end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_wrap();
        test_illegal();
        test_saturation();
        test_enable();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
